panda_dmem_responder: RTL and testbench

PANDA_DMEM_RESPONDER -- requirements
Module: panda_dmem_responder

---
 rtl/panda_dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_panda_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_dmem_responder.sv
// -----------------------------------------------------------------------------
// panda_dmem_responder
//
// Single-port data memory that answers LSU requests with a fixed-latency
// response pipeline feeding a small response FIFO.  Requests are accepted only
// while a response slot is guaranteed (credit = in-flight + queued responses),
// so the FIFO can never overflow and the pipeline never stalls.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the backing store (power of two)
//   LATENCY     : cycles from grant to FIFO entry (1..4)
//   RESP_DEPTH  : response FIFO entries (2..4)
//
// Ports
//   clk_i     in   1  clock, rising edge
//   rst_ni    in   1  asynchronous active-low reset
//   req_i     in   1  request valid
//   gnt_o     out  1  request accepted this cycle (combinational)
//   we_i      in   1  1 = store, 0 = load
//   be_i      in   4  byte enables for stores (ignored for loads)
//   addr_i    in  32  byte address, bits [1:0] ignored
//   wdata_i   in  32  store data, lane-aligned
//   rvalid_o  out  1  response valid (FIFO head)
//   rready_i  in   1  response accepted
//   rdata_o   out 32  load data; 0 for stores, errors and when idle
//   err_o     out  1  out-of-range error, qualified by rvalid_o
// -----------------------------------------------------------------------------
module panda_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 1,
   parameter int unsigned RESP_DEPTH  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   input  logic        rready_i,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned IW = $clog2(LATENCY + 1);
   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PW = $clog2(RESP_DEPTH);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [IW-1:0] inflight_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [31:0]   fifo_data [RESP_DEPTH];
   logic          fifo_err  [RESP_DEPTH];

   logic          in_range;
   logic [AW-1:0] mem_idx;
   logic          accept;
   logic          wr_en;
   logic [31:0]   acc_data;
   logic          push_valid;
   logic [31:0]   push_data;
   logic          push_err;
   logic          pop;

   // Byte offset is architecturally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_i[1:0];

   assign in_range = ({2'b00, addr_i[31:2]} < DEPTH_WORDS);
   assign mem_idx  = addr_i[AW+1:2];

   // Every granted request owns a response slot from grant until it is popped,
   // so in-flight plus queued can never exceed the FIFO size.
   assign gnt_o  = req_i && ((32'(inflight_q) + 32'(count_q)) < RESP_DEPTH);
   assign accept = gnt_o;

   // A grant seen while reset is held must not corrupt the retained contents.
   assign wr_en = accept && we_i && in_range && rst_ni;

   // NOTE: the backing store is deliberately left out of reset -- its contents
   // survive a reset, and resetting a RAM array would prevent RAM inference.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Loads sample the word at the grant edge; stores from earlier grants have
   // already landed, so there is no read-after-write hazard.
   always_comb begin
      // NOTE: default first so every path assigns acc_data -- no latch.
      acc_data = '0;
      if (!we_i && in_range) acc_data = mem[mem_idx];
   end

   // Response pipeline: with LATENCY=1 the grant writes the FIFO directly;
   // otherwise LATENCY-1 register stages delay it.
   if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_data  = acc_data;
      assign push_err   = !in_range;
   end else begin : g_pipe
      logic        v_q [LATENCY-1];
      logic [31:0] d_q [LATENCY-1];
      logic        e_q [LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 0; k < LATENCY - 1; k++) v_q[k] <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments so every stage shifts on the same
            // edge using the previous-cycle values.
            v_q[0] <= accept;
            for (int k = 1; k < LATENCY - 1; k++) v_q[k] <= v_q[k-1];
         end
      end

      // Payload is qualified by v_q, so it needs no reset.
      always_ff @(posedge clk_i) begin
         d_q[0] <= acc_data;
         e_q[0] <= !in_range;
         for (int k = 1; k < LATENCY - 1; k++) begin
            d_q[k] <= d_q[k-1];
            e_q[k] <= e_q[k-1];
         end
      end

      assign push_valid = v_q[LATENCY-2];
      assign push_data  = d_q[LATENCY-2];
      assign push_err   = e_q[LATENCY-2];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) inflight_q <= '0;
      else         inflight_q <= inflight_q + IW'(accept) - IW'(push_valid);
   end

   // Response FIFO (RESP_DEPTH need not be a power of two, so pointers wrap).
   assign rvalid_o = (count_q != '0);
   assign pop      = rvalid_o && rready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_valid) wr_ptr_q <= (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)        rd_ptr_q <= (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push_valid) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_valid) begin
         fifo_data[wr_ptr_q] <= push_data;
         fifo_err[wr_ptr_q]  <= push_err;
      end
   end

   // Head is masked when empty so outputs read zero in and after reset.
   assign rdata_o = rvalid_o ? fifo_data[rd_ptr_q] : '0;
   assign err_o   = rvalid_o && fifo_err[rd_ptr_q];

endmodule

// File: tb/tb_panda_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_panda_dmem_responder
//
// Two responders share clock and reset: instance 0 uses LATENCY=1 and
// instance 1 uses LATENCY=2, both with RESP_DEPTH=2 and DEPTH_WORDS=1024.
// A reference model tracks, per instance, the word array and an ordered list
// of granted-but-unpopped responses tagged with their grant cycle.  From those
// it derives grant, response visibility, data and error every cycle.
// -----------------------------------------------------------------------------
module tb_panda_dmem_responder;

   localparam int DW = 1024;
   localparam int RD = 2;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   logic [1:0]       req, we, gnt, rvalid, rready, err;
   logic [1:0][3:0]  be;
   logic [1:0][31:0] addr, wdata, rdata;

   always #5 clk_i = ~clk_i;

   panda_dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .RESP_DEPTH(RD)) u_dut_l1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
      .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
      .rready_i(rready[0]), .rdata_o(rdata[0]), .err_o(err[0])
   );

   panda_dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2), .RESP_DEPTH(RD)) u_dut_l2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
      .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
      .rready_i(rready[1]), .rdata_o(rdata[1]), .err_o(err[1])
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic [31:0] prime(input int w);
      return 32'hC0DE_0000 + 32'(w);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mdl_mem [2][DW];
   logic [31:0] q_d [2][16];
   logic        q_e [2][16];
   int          q_c [2][16];
   int          hd [2] = '{0, 0};
   int          tl [2] = '{0, 0};
   int          cyc = 0;

   task automatic model_accept(input int i);
      logic [31:0] idx, mask, d;
      logic        e;
      idx = {2'b00, addr[i][31:2]};
      d = '0;
      e = 1'b0;
      if (idx < DW) begin
         if (we[i]) begin
            mask = {{8{be[i][3]}}, {8{be[i][2]}}, {8{be[i][1]}}, {8{be[i][0]}}};
            mdl_mem[i][idx] = (mdl_mem[i][idx] & ~mask) | (wdata[i] & mask);
         end else begin
            d = mdl_mem[i][idx];
         end
      end else begin
         e = 1'b1;
      end
      q_d[i][tl[i] % 16] = d;
      q_e[i][tl[i] % 16] = e;
      q_c[i][tl[i] % 16] = cyc;
      tl[i]++;
   endtask

   // Compare process: every cycle, at the falling edge.
   initial begin
      int  outst;
      bit  eg, ev;
      forever begin
         @(negedge clk_i);
         for (int i = 0; i < 2; i++) begin
            if (!rst_ni) begin
               check($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
               check($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
               check($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
               hd[i] = tl[i];
            end else begin
               outst = tl[i] - hd[i];
               eg = req[i] && (outst < RD);
               ev = (outst > 0) && (cyc >= q_c[i][hd[i] % 16] + lat(i));
               check($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(eg));
               check($sformatf("rvalid%0d", i), 32'(rvalid[i]), 32'(ev));
               if (ev) begin
                  check($sformatf("rdata%0d", i), rdata[i], q_d[i][hd[i] % 16]);
                  check($sformatf("err%0d", i), 32'(err[i]), 32'(q_e[i][hd[i] % 16]));
                  if (rready[i]) hd[i]++;
               end
               if (eg) model_accept(i);
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Called just after a rising edge; returns just after the edge that granted.
   task automatic issue(input int i, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
      @(negedge clk_i);
      while (!gnt[i] && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!gnt[i]) check("grant_timeout", 32'(gnt[i]), 32'd1);
      @(posedge clk_i);
      #1;
      req[i] = 1'b0;
   endtask

   // Single request on the LATENCY=1 instance with an empty FIFO: granted at
   // once, response visible exactly one cycle later with the given values.
   task automatic lit1(input string nm, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input bit ee);
      req[0] = 1'b1; we[0] = w; be[0] = b; addr[0] = a; wdata[0] = d;
      @(negedge clk_i);
      check({nm, "_gnt"}, 32'(gnt[0]), 32'd1);
      check({nm, "_early"}, 32'(rvalid[0]), 32'd0);
      @(posedge clk_i);
      #1;
      req[0] = 1'b0;
      @(negedge clk_i);
      check({nm, "_rvalid"}, 32'(rvalid[0]), 32'd1);
      check({nm, "_rdata"}, rdata[0], ed);
      check({nm, "_err"}, 32'(err[0]), 32'(ee));
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int gcount;
      int r;
      logic [31:0] a;

      req = '0; we = '0; be = '0; addr = '0; wdata = '0; rready = '1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      idle(1);

      // Give every word the random phase touches a known value.
      for (int w = 0; w < 16; w++) begin
         issue(0, 1'b1, 4'hF, 32'(w * 4), prime(w));
         issue(1, 1'b1, 4'hF, 32'(w * 4), prime(w));
      end
      idle(4);

      lit1("st_full",   1'b1, 4'hF,    32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0);
      lit1("ld_full",   1'b0, 4'hF,    32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0);
      lit1("st_lane2",  1'b1, 4'b0100, 32'h10,   32'h00AA_0000, 32'h0,         1'b0);
      lit1("ld_merge",  1'b0, 4'hF,    32'h10,   32'h0,         32'hDEAA_BEEF, 1'b0);
      lit1("ld_unalig", 1'b0, 4'hF,    32'h13,   32'h0,         32'hDEAA_BEEF, 1'b0);
      lit1("ld_oob",    1'b0, 4'hF,    32'h1000, 32'h0,         32'h0,         1'b1);
      lit1("st_oob",    1'b1, 4'hF,    32'h1000, 32'hFFFF_FFFF, 32'h0,         1'b1);
      lit1("ld_w0",     1'b0, 4'hF,    32'h0,    32'h0,         32'hC0DE_0000, 1'b0);
      lit1("st_noop",   1'b1, 4'h0,    32'h0,    32'h1234_5678, 32'h0,         1'b0);
      lit1("ld_be0",    1'b0, 4'h0,    32'h0,    32'h0,         32'hC0DE_0000, 1'b0);
      idle(2);

      // Back-to-back loads of words 0,1,2 on the LATENCY=1 instance.
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'(k * 4);
         end else begin
            req[0] = 1'b0;
         end
         @(negedge clk_i);
         if (k < 3) check($sformatf("b2b_gnt%0d", k), 32'(gnt[0]), 32'd1);
         if (k > 0) begin
            check($sformatf("b2b_rvalid%0d", k), 32'(rvalid[0]), 32'd1);
            check($sformatf("b2b_rdata%0d", k), rdata[0], prime(k - 1));
         end
         @(posedge clk_i);
         #1;
      end
      idle(2);

      // Back-pressure on the LATENCY=2 instance: held request, rready low.
      rready[1] = 1'b0;
      req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
      gcount = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (gnt[1]) gcount++;
         @(posedge clk_i);
         #1;
         addr[1] = 32'(gcount * 4);
      end
      check("bp_grants", 32'(gcount), 32'd2);
      @(negedge clk_i);
      check("bp_blocked", 32'(gnt[1]), 32'd0);
      check("bp_head", rdata[1], prime(0));
      @(posedge clk_i);
      #1;
      rready[1] = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         if (gnt[1]) gcount++;
         @(posedge clk_i);
         #1;
         addr[1] = 32'((gcount % 16) * 4);
      end
      req[1] = 1'b0;
      idle(6);

      // Reset with one response queued and one in flight.
      rready[1] = 1'b0;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
      idle(2);
      req[1] = 1'b0;
      rst_ni = 1'b0;
      #1;
      check("rst_async_rvalid", 32'(rvalid[1]), 32'd0);
      req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h0;
      idle(2);
      req[0] = 1'b0;
      rst_ni = 1'b1;
      rready = '1;
      idle(5);
      lit1("rst_keep", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAA_BEEF, 1'b0);

      // Randomized traffic on both instances.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            req[i]   = ($urandom_range(0, 3) != 0);
            we[i]    = $urandom_range(0, 1) != 0;
            be[i]    = 4'($urandom_range(0, 15));
            wdata[i] = $urandom();
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 15));
            else             a = $urandom() | 32'h8000_0000;
            addr[i]   = a;
            rready[i] = ($urandom_range(0, 9) < (((c / 200) % 2 == 1) ? 3 : 9));
         end
         @(posedge clk_i);
         #1;
      end
      req = '0;
      rready = '1;
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
